// File: rtl/sincos_sched.sv
// Round-robin scheduler that shares one fixed-latency sincos core among NCH phase requesters.
// Optional build macro SINCOS_SCHED_PHASE_ACC_EN: req_phase becomes a per-channel frequency word feeding phase accumulators.
module sincos_sched #(
  parameter int NCH = 4,
  parameter int NBD = 25,
  parameter int LAT = 6,
  parameter int CHW = 4
) (
  input  logic                  c,
  input  logic                  rstn,
  input  logic [NCH-1:0]        req_valid,
  input  logic [NCH*26-1:0]     req_phase,
  output logic [NCH-1:0]        req_ready,
  output logic [25:0]           s_a,
  input  logic signed [NBD-1:0] s_cos,
  input  logic signed [NBD-1:0] s_sin,
  output logic                  o_valid,
  output logic [CHW-1:0]        o_ch,
  output logic signed [NBD-1:0] o_cos,
  output logic signed [NBD-1:0] o_sin
);

  localparam int IW = $clog2(NCH);

  logic [CHW-1:0]        ptr_q, ptr_d;
  logic [25:0]           s_a_q, s_a_d;
  logic                  tag_vld_q [LAT];
  logic [CHW-1:0]        tag_ch_q  [LAT];
  logic                  o_valid_q;
  logic [CHW-1:0]        o_ch_q;
  logic signed [NBD-1:0] o_cos_q, o_sin_q;

  logic [25:0]           phase_arr_s [NCH];
  logic                  gnt_any_s;
  logic [IW-1:0]         gnt_idx_s;
  logic [CHW-1:0]        gnt_ch_s;
  logic [NCH-1:0]        gnt_oh_s;
  logic [25:0]           gnt_word_s;

  // Unpack the flat per-channel phase/frequency bus
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      phase_arr_s[i] = req_phase[i*26 +: 26];
    end
  end

  // Round-robin search starting at ptr_q: the first requesting channel wins
  always_comb begin
    int          sum;
    logic [IW-1:0] idx;
    logic        take;
    sum       = 0;
    idx       = '0;
    take      = 1'b0;
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    gnt_oh_s  = '0;
    for (int off = 0; off < NCH; off++) begin
      sum  = int'(ptr_q) + off;
      idx  = (sum >= NCH) ? IW'(sum - NCH) : IW'(sum);
      take = !gnt_any_s && req_valid[idx];
      gnt_idx_s     = take ? idx : gnt_idx_s;
      gnt_oh_s[idx] = take;
      gnt_any_s     = gnt_any_s | take;
    end
    gnt_ch_s   = CHW'(gnt_idx_s);
    gnt_word_s = phase_arr_s[gnt_idx_s];
  end

`ifdef SINCOS_SCHED_PHASE_ACC_EN
  logic [25:0] acc_q [NCH];

  // Per-channel phase accumulators; only the granted channel advances
  always_ff @(posedge c or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= 26'd0;
      end
    end else if (gnt_any_s) begin
      acc_q[gnt_idx_s] <= acc_q[gnt_idx_s] + gnt_word_s;
    end
  end
`endif

  // Next pointer and next core phase; both hold when nothing is granted
  always_comb begin
    ptr_d = ptr_q;
    s_a_d = s_a_q;
    if (gnt_any_s) begin
      ptr_d = (gnt_ch_s == CHW'(NCH - 1)) ? CHW'(0) : gnt_ch_s + CHW'(1);
`ifdef SINCOS_SCHED_PHASE_ACC_EN
      s_a_d = acc_q[gnt_idx_s];
`else
      s_a_d = gnt_word_s;
`endif
    end else begin
      ptr_d = ptr_q;
      s_a_d = s_a_q;
    end
  end

  // Pointer, core phase, tag delay line and registered result
  always_ff @(posedge c or negedge rstn) begin
    if (!rstn) begin
      ptr_q     <= '0;
      s_a_q     <= 26'd0;
      for (int i = 0; i < LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_ch_q[i]  <= '0;
      end
      o_valid_q <= 1'b0;
      o_ch_q    <= '0;
      o_cos_q   <= '0;
      o_sin_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      s_a_q        <= s_a_d;
      tag_vld_q[0] <= gnt_any_s;
      tag_ch_q[0]  <= gnt_ch_s;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_ch_q[i]  <= tag_ch_q[i-1];
      end
      o_valid_q <= tag_vld_q[LAT-1];
      // Channel ID is sticky between results
      if (tag_vld_q[LAT-1]) begin
        o_ch_q <= tag_ch_q[LAT-1];
      end
      o_cos_q <= s_cos;
      o_sin_q <= s_sin;
    end
  end

  assign req_ready = gnt_oh_s;
  assign s_a       = s_a_q;
  assign o_valid   = o_valid_q;
  assign o_ch      = o_ch_q;
  assign o_cos     = o_cos_q;
  assign o_sin     = o_sin_q;

endmodule
